// File: rtl/edge_pixel_scanner.sv
// Edge pixel scanner: walks a 16-bit gradient image in raster order through an
// Avalon-MM read master and queues the (x,y) of each pixel whose value is at or
// above THRESH into a first-word fall-through coordinate FIFO.
// Optional macro EDGE_SCAN_BORDER_SKIP_EN: border pixels are read but never
// treated as edges.
module edge_pixel_scanner #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int XW         = 9,
    parameter int YW         = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          avs_s1_chipselect,
    input  logic [2:0]    avs_s1_address,
    input  logic          avs_s1_read,
    input  logic          avs_s1_write,
    input  logic [31:0]   avs_s1_writedata,
    output logic [31:0]   avs_s1_readdata,
    output logic          avs_s1_waitrequest,
    output logic [31:0]   avm_read_address,
    output logic          avm_read_read,
    input  logic [15:0]   avm_read_readdata,
    input  logic          avm_read_waitrequest,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [31:0]       base_reg;
    logic [15:0]       thresh;
    logic [31:0]       addr;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [15:0]       pixel;
    logic [31:0]       edge_count;
    logic              busy;
    logic              done_flag;
    logic              read_delayed;
    logic [31:0]       rd_mux;

    logic [XW+YW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              border;
    logic              is_edge;
    logic              last_pixel;
    logic              start_accept;

    assign fifo_full    = (count == FULL_CNT);
    assign out_valid    = (count != '0);
    assign pop          = out_valid & out_ready;
    assign out_x        = fifo_mem[rd_ptr][XW-1:0];
    assign out_y        = fifo_mem[rd_ptr][XW+YW-1:XW];
    assign last_pixel   = (x == X_LAST) && (y == Y_LAST);
    assign start_accept = avs_s1_chipselect && avs_s1_write && (avs_s1_address == 3'd2)
                          && ((state == IDLE) || (state == DONE));

    // Slave stalls only the first cycle of a read; writes never stall.
    assign avs_s1_waitrequest = avs_s1_chipselect & avs_s1_read & ~read_delayed;

    // Register file read mux
    always_comb begin
        rd_mux = '0;
        case (avs_s1_address)
            3'd0:    rd_mux = base_reg;
            3'd1:    rd_mux = {16'h0000, thresh};
            3'd3:    rd_mux = {30'b0, busy, done_flag};
            3'd4:    rd_mux = edge_count;
            default: rd_mux = '0;
        endcase
    end

    // Slave read pipeline and writable configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_delayed    <= 1'b0;
            avs_s1_readdata <= '0;
            base_reg        <= '0;
            thresh          <= '0;
        end else begin
            read_delayed <= avs_s1_chipselect & avs_s1_read & ~read_delayed;
            if (avs_s1_chipselect && avs_s1_read && !read_delayed)
                avs_s1_readdata <= rd_mux;
            if (avs_s1_chipselect && avs_s1_write) begin
                case (avs_s1_address)
                    3'd0:    base_reg <= avs_s1_writedata;
                    3'd1:    thresh   <= avs_s1_writedata[15:0];
                    default: ;
                endcase
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_accept) state_next = ISSUE;
            ISSUE: if (!fifo_full) state_next = WAIT;
            WAIT:  if (!avm_read_waitrequest) state_next = EVAL;
            EVAL:  state_next = last_pixel ? DRAIN : ISSUE;
            DRAIN: if (!out_valid) state_next = DONE;
            DONE:  state_next = start_accept ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: read request and edge decision
    always_comb begin
`ifdef EDGE_SCAN_BORDER_SKIP_EN
        border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
`else
        border = 1'b0;
`endif
        is_edge          = (pixel >= thresh) && !border;
        push             = (state == EVAL) && is_edge;
        avm_read_read    = ((state == ISSUE) && !fifo_full) || (state == WAIT);
        avm_read_address = addr;
    end

    // Scan datapath: pixel capture, coordinates, address, counters, status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            x          <= '0;
            y          <= '0;
            pixel      <= '0;
            edge_count <= '0;
            busy       <= 1'b0;
            done_flag  <= 1'b0;
        end else begin
            if ((state == WAIT) && !avm_read_waitrequest)
                pixel <= avm_read_readdata;
            if (state == EVAL) begin
                if (is_edge) edge_count <= edge_count + 32'd1;
                addr <= addr + 32'd2;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (state == DONE) begin
                done_flag <= 1'b1;
                busy      <= 1'b0;
            end
            // A START in DONE must win over the DONE-state status update.
            if (start_accept) begin
                done_flag  <= 1'b0;
                edge_count <= '0;
                x          <= '0;
                y          <= '0;
                addr       <= base_reg;
                busy       <= 1'b1;
            end
        end
    end

    // Coordinate FIFO, cleared on START
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (start_accept) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {y, x};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_pixel_scanner.sv
// Directed bench for edge_pixel_scanner on a tiny 4-wide image with a
// 2-entry FIFO; the border-skip variant is exercised when
// EDGE_SCAN_BORDER_SKIP_EN is defined.
module tb_edge_pixel_scanner;

    localparam int TB_W = 4;
`ifdef EDGE_SCAN_BORDER_SKIP_EN
    localparam int TB_H = 3;
`else
    localparam int TB_H = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, rd, wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] readdata;
    logic        waitreq;
    logic [31:0] avm_addr;
    logic        avm_rd;
    logic [15:0] avm_rdata;
    logic        avm_wr;
    logic        out_valid, out_ready;
    logic [8:0]  out_x;
    logic [7:0]  out_y;

    always #5 clk = ~clk;

    edge_pixel_scanner #(.IMG_W(TB_W), .IMG_H(TB_H), .XW(9), .YW(8), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .avs_s1_chipselect(cs), .avs_s1_address(addr), .avs_s1_read(rd),
        .avs_s1_write(wr), .avs_s1_writedata(wdata), .avs_s1_readdata(readdata),
        .avs_s1_waitrequest(waitreq),
        .avm_read_address(avm_addr), .avm_read_read(avm_rd),
        .avm_read_readdata(avm_rdata), .avm_read_waitrequest(avm_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: combinational data, waitrequest held for wait_cycles per read
    logic [15:0] mem [16];
    logic [31:0] mem_base;
    int          wait_cycles;
    int          wcnt;

    always_comb avm_rdata = mem[4'((avm_addr - mem_base) >> 1)];
    always_comb avm_wr = avm_rd && (wcnt < wait_cycles);
    always @(posedge clk) wcnt <= avm_rd ? wcnt + 1 : 0;

    // Observers: read addresses, popped coordinates, stability violations
    logic [31:0] addr_log [32];
    logic [31:0] out_log  [32];
    int          n_addr, n_out, stab_err, hold_err;
    logic        prev_rd, prev_hold, log_clr;
    logic [31:0] prev_addr;
    logic [16:0] prev_xy;

    always @(posedge clk) begin
        prev_rd   <= avm_rd;
        prev_addr <= avm_addr;
        prev_hold <= out_valid && !out_ready;
        prev_xy   <= {out_y, out_x};
        if (log_clr) begin
            n_addr <= 0; n_out <= 0; stab_err <= 0; hold_err <= 0;
        end else begin
            if (avm_rd && !prev_rd && n_addr < 32) begin
                addr_log[n_addr] <= avm_addr;
                n_addr <= n_addr + 1;
            end
            if (avm_rd && prev_rd && avm_addr != prev_addr) stab_err <= stab_err + 1;
            if (out_valid && out_ready && n_out < 32) begin
                out_log[n_out] <= {15'b0, out_y, out_x};
                n_out <= n_out + 1;
            end
            if (prev_hold && (!out_valid || {out_y, out_x} != prev_xy)) hold_err <= hold_err + 1;
        end
    end

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        d = readdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic start_scan();
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0;
        reg_write(3'd2, 32'hDEAD_BEEF);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 300; i++) begin
            reg_read(3'd3, s);
            if (s[0]) break;
        end
        chk(tag, s, 32'h1);
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    // Expected packed {y,x} of raster pixel i
    function automatic logic [31:0] xy_of(input int i);
        logic [31:0] v;
        v = ((i / TB_W) << 9) | (i % TB_W);
        return v;
    endfunction

    task automatic check_addrs(input string tag, input int n);
        chk({tag, "_naddr"}, n_addr, n);
        for (int i = 0; i < n; i++) chk({tag, "_addr"}, addr_log[i], mem_base + 32'(2 * i));
    endtask

    logic [31:0] r;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
        out_ready = 1'b1; log_clr = 1'b0; wait_cycles = 0; mem_base = 32'h1000;
        fill_mem(16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_read", avm_rd, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", avm_addr, 0);
        reg_read(3'd3, r); chk("rst_status", r, 0);
        reg_read(3'd4, r); chk("rst_count", r, 0);
        reg_read(3'd0, r); chk("rst_base", r, 0);

        // Register file behaviour and slave read timing
        reg_write(3'd1, 32'hABCD_0080);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 3'd1;
        #1 chk("wr_first", waitreq, 1);
        @(negedge clk);
        chk("wr_second", waitreq, 0);
        chk("thresh_rd", readdata, 32'h0000_0080);
        cs = 1'b0; rd = 1'b0;
        reg_write(3'd5, 32'h1234_5678);
        reg_read(3'd5, r); chk("unused_rd", r, 0);
        reg_write(3'd0, 32'h0000_1000);
        reg_read(3'd0, r); chk("base_rd", r, 32'h1000);

`ifdef EDGE_SCAN_BORDER_SKIP_EN
        // Border skip: only interior pixels of a 4x3 all-0xFFFF image are edges
        fill_mem(16'hFFFF);
        reg_write(3'd1, 32'h0000_FFFF);
        start_scan();
        wait_done("bs_done");
        check_addrs("bs", 12);
        chk("bs_nout", n_out, 2);
        chk("bs_out0", out_log[0], xy_of(5));
        chk("bs_out1", out_log[1], xy_of(6));
        reg_read(3'd4, r); chk("bs_count", r, 2);
`else
        // Basic scan: pixels 1 and 6 above threshold
        mem[1] = 16'h0100; mem[6] = 16'h0100;
        start_scan();
        wait_done("t1_done");
        check_addrs("t1", 8);
        chk("t1_nout", n_out, 2);
        chk("t1_out0", out_log[0], xy_of(1));
        chk("t1_out1", out_log[1], xy_of(6));
        reg_read(3'd4, r); chk("t1_count", r, 2);

        // Memory stalls of 5 cycles plus an ignored mid-scan START
        wait_cycles = 5;
        start_scan();
        repeat (10) @(negedge clk);
        reg_write(3'd2, 32'h0);
        reg_read(3'd3, r); chk("t3_busy", r, 32'h2);
        wait_done("t3_done");
        check_addrs("t3", 8);
        chk("t3_stable", stab_err, 0);
        chk("t3_nout", n_out, 2);
        chk("t3_out0", out_log[0], xy_of(1));
        chk("t3_out1", out_log[1], xy_of(6));
        reg_read(3'd4, r); chk("t3_count", r, 2);
        wait_cycles = 0;

        // Backpressure: FIFO of 2 fills and scan stalls in ISSUE
        fill_mem(16'hFFFF);
        reg_write(3'd1, 32'h0000_FFFF);
        out_ready = 1'b0;
        start_scan();
        repeat (40) @(negedge clk);
        chk("t2_naddr_stall", n_addr, 2);
        chk("t2_valid", out_valid, 1);
        chk("t2_head", {15'b0, out_y, out_x}, xy_of(0));
        chk("t2_nout_stall", n_out, 0);
        reg_read(3'd3, r); chk("t2_busy", r, 32'h2);
        reg_read(3'd4, r); chk("t2_count_stall", r, 2);
        out_ready = 1'b1;
        wait_done("t2_done");
        chk("t2_hold", hold_err, 0);
        chk("t2_nout", n_out, 8);
        for (int i = 0; i < 8; i++) chk("t2_out", out_log[i], xy_of(i));
        reg_read(3'd4, r); chk("t2_count", r, 8);

        // THRESH=0xFFFF: only exact 0xFFFF qualifies
        fill_mem(16'h7FFF);
        mem[2] = 16'hFFFF; mem[5] = 16'hFFFE;
        start_scan();
        wait_done("t4_done");
        chk("t4_nout", n_out, 1);
        chk("t4_out0", out_log[0], xy_of(2));
        reg_read(3'd4, r); chk("t4_count", r, 1);

        // THRESH=0 with a base that wraps past 2^32
        fill_mem(16'h0000);
        mem_base = 32'hFFFF_FFFA;
        reg_write(3'd0, mem_base);
        reg_write(3'd1, 32'h0);
        start_scan();
        wait_done("t5_done");
        check_addrs("t5", 8);
        chk("t5_nout", n_out, 8);
        reg_read(3'd4, r); chk("t5_count", r, 8);

        // Asynchronous reset mid-scan
        fill_mem(16'hFFFF);
        wait_cycles = 5;
        out_ready = 1'b0;
        start_scan();
        repeat (9) @(negedge clk);
        chk("t6_pre_read", avm_rd, 1);
        chk("t6_pre_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6_read", avm_rd, 0);
        chk("t6_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        reg_read(3'd3, r); chk("t6_status", r, 0);
        reg_read(3'd4, r); chk("t6_count", r, 0);
        chk("t6_read_after", avm_rd, 0);
        wait_cycles = 0;
        out_ready = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
